response_router: RTL

- Return-path block that sits after shared_resource. It routes each resource response (data, id, valid) back to the pipeline/requester that issued it.
- Holds a per-ID scoreboard of outstanding requests, loaded by the arbiter's accepted grants. Drops responses whose ID was flushed by the producer while in flight.
- Buffers delivered responses in one small FIFO per channel, drained by a valid/ready handshake toward consumer logic.

---
 rtl/response_router_if.sv | 35 +++
 rtl/response_router.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/response_router_if.sv
// Response bus and per-channel consumer handshake between the shared resource,
// the response router and the two downstream consumers.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

interface response_router_if #(
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ID_W   = `ID_WIDTH
);
  logic [DATA_W-1:0] in_data;
  logic [ID_W-1:0]   in_id;
  logic              in_valid;
  logic [DATA_W-1:0] out_data_1;
  logic [DATA_W-1:0] out_data_2;
  logic [ID_W-1:0]   out_id_1;
  logic [ID_W-1:0]   out_id_2;
  logic              out_valid_1;
  logic              out_valid_2;
  logic              in_ready_1;
  logic              in_ready_2;

  modport slave (
    input  in_data, in_id, in_valid, in_ready_1, in_ready_2,
    output out_data_1, out_data_2, out_id_1, out_id_2, out_valid_1, out_valid_2
  );

  modport master (
    output in_data, in_id, in_valid, in_ready_1, in_ready_2,
    input  out_data_1, out_data_2, out_id_1, out_id_2, out_valid_1, out_valid_2
  );
endinterface

// File: rtl/response_router.sv
// Routes resource responses back to the issuing channel using a per-ID scoreboard,
// discarding flushed responses and buffering deliveries in one FIFO per channel.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module response_router #(
  parameter int DATA_W     = `DATA_WIDTH,
  parameter int ID_W       = `ID_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_issue_valid,
  input  logic            in_issue_choice,
  input  logic [ID_W-1:0] in_issue_id,
  input  logic            in_flush_1,
  input  logic            in_flush_2,
  input  logic [ID_W-1:0] in_flush_id_1,
  input  logic [ID_W-1:0] in_flush_id_2,
  response_router_if.slave bus,
  output logic            err_spurious,
  output logic            err_dup,
  output logic            err_overflow,
  output logic [7:0]      drop_count
);
  localparam int N_ID  = 1 << ID_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [N_ID-1:0] pending_reg, pending_next;
  logic [N_ID-1:0] flushed_reg, flushed_next;
  logic [N_ID-1:0] owner_reg, owner_next;

  logic [1:0] push, pop, full, valid, ready;
  logic [DATA_W-1:0] head_data [2];
  logic [ID_W-1:0]   head_id [2];

  logic spurious_set, dup_set, overflow_set, drop_inc;
  logic spurious_reg, dup_reg, overflow_reg;
  logic [7:0] drop_count_reg;

  assign ready = {bus.in_ready_2, bus.in_ready_1};

  // Response first, then flushes see the post-response pending state, then issue.
  always_comb begin
    pending_next = pending_reg;
    flushed_next = flushed_reg;
    owner_next   = owner_reg;
    push         = 2'b00;
    spurious_set = 1'b0;
    dup_set      = 1'b0;
    overflow_set = 1'b0;
    drop_inc     = 1'b0;

    if (bus.in_valid) begin
      if (!pending_reg[bus.in_id]) begin
        spurious_set = 1'b1;
      end else begin
        pending_next[bus.in_id] = 1'b0;
        flushed_next[bus.in_id] = 1'b0;
        if (flushed_reg[bus.in_id])
          drop_inc = 1'b1;
        else if (full[owner_reg[bus.in_id]] && !pop[owner_reg[bus.in_id]])
          overflow_set = 1'b1;
        else
          push[owner_reg[bus.in_id]] = 1'b1;
      end
    end

    if (in_flush_1 && pending_next[in_flush_id_1] && !owner_reg[in_flush_id_1])
      flushed_next[in_flush_id_1] = 1'b1;
    if (in_flush_2 && pending_next[in_flush_id_2] && owner_reg[in_flush_id_2])
      flushed_next[in_flush_id_2] = 1'b1;

    if (in_issue_valid) begin
      dup_set                   = pending_next[in_issue_id];
      pending_next[in_issue_id] = 1'b1;
      flushed_next[in_issue_id] = 1'b0;
      owner_next[in_issue_id]   = in_issue_choice;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg    <= '0;
      flushed_reg    <= '0;
      owner_reg      <= '0;
      spurious_reg   <= 1'b0;
      dup_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      pending_reg  <= pending_next;
      flushed_reg  <= flushed_next;
      owner_reg    <= owner_next;
      spurious_reg <= spurious_reg | spurious_set;
      dup_reg      <= dup_reg | dup_set;
      overflow_reg <= overflow_reg | overflow_set;
      if (drop_inc && drop_count_reg != 8'hFF)
        drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [DATA_W+ID_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    assign valid[gi] = (count_reg != '0);
    assign full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop[gi]   = valid[gi] & ready[gi];
    // Head is forced to zero while empty so idle outputs read as 0.
    assign head_data[gi] = valid[gi] ? mem[rd_ptr_reg][DATA_W+ID_W-1:ID_W] : '0;
    assign head_id[gi]   = valid[gi] ? mem[rd_ptr_reg][ID_W-1:0] : '0;

    always_ff @(posedge clk) begin
      if (push[gi])
        mem[wr_ptr_reg] <= {bus.in_data, bus.in_id};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push[gi])
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi])
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push[gi] && !pop[gi])
          count_reg <= count_reg + 1'b1;
        else if (pop[gi] && !push[gi])
          count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign bus.out_valid_1 = valid[0];
  assign bus.out_valid_2 = valid[1];
  assign bus.out_data_1  = head_data[0];
  assign bus.out_data_2  = head_data[1];
  assign bus.out_id_1    = head_id[0];
  assign bus.out_id_2    = head_id[1];

  assign err_spurious = spurious_reg;
  assign err_dup      = dup_reg;
  assign err_overflow = overflow_reg;
  assign drop_count   = drop_count_reg;
endmodule
